// File: rtl/pacman_motion.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_motion
//  Description : Per-frame Pac-Man motion update with wall query handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pacman_motion #(
    parameter int START_X    = 304,
    parameter int START_Y    = 224,
    parameter int STEP       = 2,
    parameter int FRAME_DIV  = 1,
    parameter int FRAME_LINE = 480,
    parameter int MIN_X      = 0,
    parameter int MAX_X      = 610,
    parameter int MIN_Y      = 0,
    parameter int MAX_Y      = 450
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic [9:0] vC,
    input  logic [9:0] hC,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       q_valid,
    output logic [9:0] q_xpos,
    output logic [9:0] q_ypos,
    input  logic       q_ready,
    input  logic       q_blocked,
    output logic [9:0] pm_xpos,
    output logic [9:0] pm_ypos,
    output logic [3:0] pm_direction,
    output logic       pm_stalled,
    output logic       frame_overrun
);

    localparam logic [3:0]  c_DIR_R      = 4'b0001;
    localparam logic [3:0]  c_DIR_L      = 4'b0010;
    localparam logic [3:0]  c_DIR_U      = 4'b0100;
    localparam logic [3:0]  c_DIR_D      = 4'b1000;
    localparam logic [10:0] c_STEP       = 11'(STEP);
    localparam logic [9:0]  c_STEP10     = 10'(STEP);
    localparam logic [10:0] c_MIN_X      = 11'(MIN_X);
    localparam logic [10:0] c_MAX_X      = 11'(MAX_X);
    localparam logic [10:0] c_MIN_Y      = 11'(MIN_Y);
    localparam logic [10:0] c_MAX_Y      = 11'(MAX_Y);
    localparam logic [9:0]  c_MIN_X10    = 10'(MIN_X);
    localparam logic [9:0]  c_MAX_X10    = 10'(MAX_X);
    localparam logic [9:0]  c_START_X    = 10'(START_X);
    localparam logic [9:0]  c_START_Y    = 10'(START_Y);
    localparam logic [9:0]  c_FRAME_LINE = 10'(FRAME_LINE);
    localparam int          c_DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TURN_Q = 2'd1,
        S_FWD_Q  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_line;
    logic               r_line_d;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_pending;
    logic [3:0]         r_turn_dir;
    logic               r_is_turn;
    logic               r_cand_blk;

    logic               w_tick;
    logic               w_fire;
    logic [20:0]        w_turn_step;
    logic [20:0]        w_fwd_step;

    // Candidate one step away; bit 20 flags a vertical move off the playfield.
    function automatic logic [20:0] f_step(input logic [3:0] dir,
                                           input logic [9:0] x,
                                           input logic [9:0] y);
        logic [9:0] nx;
        logic [9:0] ny;
        logic       blk;
        nx  = x;
        ny  = y;
        blk = 1'b0;
        if (dir == c_DIR_R) begin
            nx = (({1'b0, x} + c_STEP) > c_MAX_X) ? c_MIN_X10 : x + c_STEP10;
        end else if (dir == c_DIR_L) begin
            nx = ({1'b0, x} < (c_MIN_X + c_STEP)) ? c_MAX_X10 : x - c_STEP10;
        end else if (dir == c_DIR_U) begin
            if ({1'b0, y} < (c_MIN_Y + c_STEP)) blk = 1'b1;
            else                                ny  = y - c_STEP10;
        end else if (dir == c_DIR_D) begin
            if (({1'b0, y} + c_STEP) > c_MAX_Y) blk = 1'b1;
            else                                ny  = y + c_STEP10;
        end
        return {blk, nx, ny};
    endfunction

    assign w_tick      = r_line & ~r_line_d;
    assign w_fire      = w_tick && (r_div == c_DIV_LAST);
    assign w_turn_step = f_step(r_pending, pm_xpos, pm_ypos);
    assign w_fwd_step  = f_step(pm_direction, pm_xpos, pm_ypos);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_line        <= 1'b0;
            r_line_d      <= 1'b0;
            r_div         <= '0;
            r_pending     <= 4'b0000;
            r_turn_dir    <= c_DIR_R;
            r_is_turn     <= 1'b0;
            r_cand_blk    <= 1'b0;
            q_valid       <= 1'b0;
            q_xpos        <= 10'd0;
            q_ypos        <= 10'd0;
            pm_xpos       <= c_START_X;
            pm_ypos       <= c_START_Y;
            pm_direction  <= c_DIR_R;
            pm_stalled    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            r_line        <= (vC == c_FRAME_LINE) && (hC == 10'd0);
            r_line_d      <= r_line;
            frame_overrun <= w_tick && (r_state != S_IDLE);

            if (w_tick) begin
                r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            end

            // A committing turn consumes the request even if a button is still held.
            if (r_state == S_COMMIT && r_is_turn) r_pending <= 4'b0000;
            else if (btn_up)                      r_pending <= c_DIR_U;
            else if (btn_down)                    r_pending <= c_DIR_D;
            else if (btn_left)                    r_pending <= c_DIR_L;
            else if (btn_right)                   r_pending <= c_DIR_R;

            case (r_state)
                S_IDLE: begin
                    if (w_fire && game_en) begin
                        if (r_pending != 4'b0000 && r_pending != pm_direction) begin
                            r_state    <= S_TURN_Q;
                            r_turn_dir <= r_pending;
                            r_cand_blk <= w_turn_step[20];
                            q_valid    <= ~w_turn_step[20];
                            q_xpos     <= w_turn_step[19:10];
                            q_ypos     <= w_turn_step[9:0];
                        end else begin
                            r_state    <= S_FWD_Q;
                            r_cand_blk <= w_fwd_step[20];
                            q_valid    <= ~w_fwd_step[20];
                            q_xpos     <= w_fwd_step[19:10];
                            q_ypos     <= w_fwd_step[9:0];
                        end
                    end
                end
                S_TURN_Q: begin
                    if (r_cand_blk || (q_valid && q_ready)) begin
                        if (!r_cand_blk && !q_blocked) begin
                            r_state   <= S_COMMIT;
                            r_is_turn <= 1'b1;
                            q_valid   <= 1'b0;
                        end else begin
                            r_state    <= S_FWD_Q;
                            r_cand_blk <= w_fwd_step[20];
                            q_valid    <= ~w_fwd_step[20];
                            q_xpos     <= w_fwd_step[19:10];
                            q_ypos     <= w_fwd_step[9:0];
                        end
                    end
                end
                S_FWD_Q: begin
                    if (r_cand_blk || (q_valid && q_ready)) begin
                        q_valid <= 1'b0;
                        if (!r_cand_blk && !q_blocked) begin
                            r_state   <= S_COMMIT;
                            r_is_turn <= 1'b0;
                        end else begin
                            r_state    <= S_IDLE;
                            pm_stalled <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    pm_xpos    <= q_xpos;
                    pm_ypos    <= q_ypos;
                    pm_stalled <= 1'b0;
                    r_state    <= S_IDLE;
                    // Direction latched at query time so it always matches the candidate.
                    if (r_is_turn) pm_direction <= r_turn_dir;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pacman_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pacman_motion
//  Description : Directed self-checking bench for pacman_motion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_en = 1'b1;
    logic [9:0] vC = 10'd0;
    logic [9:0] hC = 10'd0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       q_valid, q_ready = 1'b1, q_blocked;
    logic [9:0] q_xpos, q_ypos, pm_xpos, pm_ypos;
    logic [3:0] pm_direction;
    logic       pm_stalled, frame_overrun;
    logic       block_vert = 1'b0;

    int total = 0;
    int bad = 0;
    int ov_cnt = 0;

    always #5 clk = ~clk;

    // Wall model: optionally every vertical move is blocked.
    assign q_blocked = block_vert && (q_ypos != pm_ypos);

    always @(negedge clk) if (frame_overrun) ov_cnt++;

    pacman_motion dut (
        .clk(clk), .rst(rst), .game_en(game_en), .vC(vC), .hC(hC),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .q_valid(q_valid), .q_xpos(q_xpos), .q_ypos(q_ypos),
        .q_ready(q_ready), .q_blocked(q_blocked),
        .pm_xpos(pm_xpos), .pm_ypos(pm_ypos), .pm_direction(pm_direction),
        .pm_stalled(pm_stalled), .frame_overrun(frame_overrun)
    );

    // Returns on the negedge during which the internal tick is high.
    task automatic pulse_tick();
        @(negedge clk); vC = 10'd480; hC = 10'd0;
        @(negedge clk); vC = 10'd0;   hC = 10'd1;
    endtask

    task automatic tick_settle();
        pulse_tick();
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pm_xpos !== 10'd304) begin bad++; $display("FAIL reset_x got=%0d want=304", pm_xpos); end
        total++; if (pm_ypos !== 10'd224) begin bad++; $display("FAIL reset_y got=%0d want=224", pm_ypos); end
        total++; if (pm_direction !== 4'b0001) begin bad++; $display("FAIL reset_dir got=%b want=0001", pm_direction); end
        total++; if (q_valid !== 1'b0 || q_xpos !== 10'd0 || q_ypos !== 10'd0) begin
            bad++; $display("FAIL reset_q got v=%b x=%0d y=%0d want 0/0/0", q_valid, q_xpos, q_ypos); end
        total++; if (pm_stalled !== 1'b0 || frame_overrun !== 1'b0) begin
            bad++; $display("FAIL reset_flags got st=%b ov=%b want 0/0", pm_stalled, frame_overrun); end
    endtask

    task automatic test_forward();
        pulse_tick();
        @(negedge clk);
        total++; if (q_valid !== 1'b1 || q_xpos !== 10'd306 || q_ypos !== 10'd224) begin
            bad++; $display("FAIL fwd_query got v=%b x=%0d y=%0d want 1/306/224", q_valid, q_xpos, q_ypos); end
        @(negedge clk);
        total++; if (q_valid !== 1'b0 || pm_xpos !== 10'd304) begin
            bad++; $display("FAIL fwd_latency got v=%b x=%0d want 0/304", q_valid, pm_xpos); end
        @(negedge clk);
        total++; if (pm_xpos !== 10'd306) begin bad++; $display("FAIL fwd_x1 got=%0d want=306", pm_xpos); end
        tick_settle();
        total++; if (pm_xpos !== 10'd308) begin bad++; $display("FAIL fwd_x2 got=%0d want=308", pm_xpos); end
        tick_settle();
        total++; if (pm_xpos !== 10'd310 || pm_ypos !== 10'd224 || pm_direction !== 4'b0001) begin
            bad++; $display("FAIL fwd_x3 got x=%0d y=%0d d=%b want 310/224/0001", pm_xpos, pm_ypos, pm_direction); end
    endtask

    task automatic test_turn();
        btn_up = 1'b1;
        pulse_tick();
        btn_up = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (pm_direction !== 4'b0100 || pm_ypos !== 10'd222 || pm_xpos !== 10'd310) begin
            bad++; $display("FAIL turn_up got d=%b x=%0d y=%0d want 0100/310/222", pm_direction, pm_xpos, pm_ypos); end
        tick_settle();
        total++; if (pm_ypos !== 10'd220 || pm_direction !== 4'b0100) begin
            bad++; $display("FAIL turn_cont got d=%b y=%0d want 0100/220", pm_direction, pm_ypos); end
    endtask

    task automatic test_turn_blocked();
        btn_right = 1'b1;
        pulse_tick();
        btn_right = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (pm_direction !== 4'b0001 || pm_xpos !== 10'd312 || pm_ypos !== 10'd220) begin
            bad++; $display("FAIL turn_right got d=%b x=%0d y=%0d want 0001/312/220", pm_direction, pm_xpos, pm_ypos); end
        block_vert = 1'b1;
        btn_up = 1'b1;
        pulse_tick();
        btn_up = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (pm_direction !== 4'b0001 || pm_xpos !== 10'd314 || pm_ypos !== 10'd220 || pm_stalled !== 1'b0) begin
            bad++; $display("FAIL turn_blk_fwd got d=%b x=%0d y=%0d st=%b want 0001/314/220/0",
                            pm_direction, pm_xpos, pm_ypos, pm_stalled); end
        block_vert = 1'b0;
        tick_settle();
        total++; if (pm_direction !== 4'b0100 || pm_xpos !== 10'd314 || pm_ypos !== 10'd218) begin
            bad++; $display("FAIL turn_retry got d=%b x=%0d y=%0d want 0100/314/218", pm_direction, pm_xpos, pm_ypos); end
    endtask

    task automatic test_wrap_edges();
        int qv_seen;
        do_reset();
        btn_left = 1'b1;
        pulse_tick();
        btn_left = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 1; i < 152; i++) tick_settle();
        total++; if (pm_xpos !== 10'd0 || pm_direction !== 4'b0010) begin
            bad++; $display("FAIL left_edge got x=%0d d=%b want 0/0010", pm_xpos, pm_direction); end
        pulse_tick();
        @(negedge clk);
        total++; if (q_valid !== 1'b1 || q_xpos !== 10'd610) begin
            bad++; $display("FAIL wrap_query got v=%b x=%0d want 1/610", q_valid, q_xpos); end
        repeat (4) @(negedge clk);
        total++; if (pm_xpos !== 10'd610 || pm_ypos !== 10'd224) begin
            bad++; $display("FAIL wrap_x got x=%0d y=%0d want 610/224", pm_xpos, pm_ypos); end
        btn_up = 1'b1;
        pulse_tick();
        btn_up = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 1; i < 112; i++) tick_settle();
        total++; if (pm_ypos !== 10'd0 || pm_xpos !== 10'd610 || pm_direction !== 4'b0100) begin
            bad++; $display("FAIL top_edge got x=%0d y=%0d d=%b want 610/0/0100", pm_xpos, pm_ypos, pm_direction); end
        qv_seen = 0;
        pulse_tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (q_valid) qv_seen++;
        end
        total++; if (qv_seen !== 0) begin bad++; $display("FAIL top_noquery got qvalid_cycles=%0d want=0", qv_seen); end
        total++; if (pm_stalled !== 1'b1 || pm_ypos !== 10'd0) begin
            bad++; $display("FAIL top_stall got st=%b y=%0d want 1/0", pm_stalled, pm_ypos); end
        btn_down = 1'b1;
        pulse_tick();
        btn_down = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (pm_stalled !== 1'b0 || pm_ypos !== 10'd2 || pm_direction !== 4'b1000) begin
            bad++; $display("FAIL down_move got st=%b y=%0d d=%b want 0/2/1000", pm_stalled, pm_ypos, pm_direction); end
    endtask

    task automatic test_overrun();
        int ov_base;
        ov_base = ov_cnt;
        q_ready = 1'b0;
        pulse_tick();
        repeat (3) @(negedge clk);
        total++; if (q_valid !== 1'b1 || q_xpos !== 10'd610 || q_ypos !== 10'd4 || ov_cnt - ov_base !== 0) begin
            bad++; $display("FAIL ovr_wait got v=%b x=%0d y=%0d ov=%0d want 1/610/4/0",
                            q_valid, q_xpos, q_ypos, ov_cnt - ov_base); end
        pulse_tick();
        @(negedge clk);
        total++; if (frame_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", frame_overrun); end
        @(negedge clk);
        total++; if (frame_overrun !== 1'b0) begin bad++; $display("FAIL ovr_width got=%b want=0", frame_overrun); end
        pulse_tick();
        repeat (3) @(negedge clk);
        total++; if (ov_cnt - ov_base !== 2 || q_xpos !== 10'd610 || q_ypos !== 10'd4 || q_valid !== 1'b1) begin
            bad++; $display("FAIL ovr_count got ov=%0d v=%b x=%0d y=%0d want 2/1/610/4",
                            ov_cnt - ov_base, q_valid, q_xpos, q_ypos); end
        q_ready = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (pm_ypos !== 10'd4 || q_valid !== 1'b0 || pm_ypos === 10'd6) begin
            bad++; $display("FAIL ovr_commit got y=%0d v=%b want 4/0", pm_ypos, q_valid); end
    endtask

    task automatic test_reset_abort();
        int qv_seen;
        q_ready = 1'b0;
        btn_left = 1'b1;
        pulse_tick();
        btn_left = 1'b0;
        @(negedge clk);
        total++; if (q_valid !== 1'b1 || q_xpos !== 10'd608 || q_ypos !== 10'd4) begin
            bad++; $display("FAIL abort_query got v=%b x=%0d y=%0d want 1/608/4", q_valid, q_xpos, q_ypos); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (q_valid !== 1'b0 || pm_xpos !== 10'd304 || pm_ypos !== 10'd224 || pm_direction !== 4'b0001) begin
            bad++; $display("FAIL abort_reset got v=%b x=%0d y=%0d d=%b want 0/304/224/0001",
                            q_valid, pm_xpos, pm_ypos, pm_direction); end
        q_ready = 1'b1;
        game_en = 1'b0;
        qv_seen = 0;
        for (int t = 0; t < 2; t++) begin
            pulse_tick();
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (q_valid) qv_seen++;
            end
        end
        total++; if (qv_seen !== 0 || pm_xpos !== 10'd304 || pm_ypos !== 10'd224) begin
            bad++; $display("FAIL disabled got qv=%0d x=%0d y=%0d want 0/304/224", qv_seen, pm_xpos, pm_ypos); end
        game_en = 1'b1;
        tick_settle();
        total++; if (pm_xpos !== 10'd306 || pm_direction !== 4'b0001) begin
            bad++; $display("FAIL reenable got x=%0d d=%b want 306/0001", pm_xpos, pm_direction); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_turn();
        test_turn_blocked();
        test_wrap_edges();
        test_overrun();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
